// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state codes,
// length-field width and the default program-size limit.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int MAX_WORDS_DEF  = 1024;
    localparam int BYTES_PER_WORD = 4;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LEN_HI = 3'd1;
    localparam logic [ST_W-1:0] ST_LEN_LO = 3'd2;
    localparam logic [ST_W-1:0] ST_BYTES  = 3'd3;
    localparam logic [ST_W-1:0] ST_WRITE  = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/byte_packer.sv
// Shifts consumed bytes into a 32-bit big-endian word and flags the byte
// that completes it.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
        end else if (byte_en_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {word_q[23:0], byte_i};
        end
    end

    assign last_o = byte_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program from a byte interface into instruction
// memory while holding the processor, then releases it on a legal load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    logic [ST_W-1:0]   state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  n_full;
    logic              accept;
    logic              sess_start;
    logic              word_last;
    logic [31:0]       word;

    assign rx_ready   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_BYTES);
    assign accept     = rx_valid && rx_ready;
    assign sess_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign n_full     = {len_q[15:8], rx_data};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (sess_start),
        .byte_en_i (accept && (state_q == ST_BYTES)),
        .byte_i    (rx_data),
        .word_o    (word),
        .last_o    (word_last)
    );

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = n_full;
                    if (n_full == '0) begin
                        state_d = ST_DONE;
                    end else if (n_full > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BYTES;
                    end
                end
            end
            ST_BYTES: begin
                if (word_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // len_q counts words still owed, so the last write sees 1.
                idx_d   = idx_q + 1'b1;
                len_d   = len_q - 1'b1;
                state_d = (len_q == 16'd1) ? ST_DONE : ST_BYTES;
            end
            ST_DONE: begin
                if (start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    len_d   = '0;
                    state_d = ST_LEN_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign im_we    = (state_q == ST_WRITE);
    assign im_addr  = idx_q;
    assign im_wdata = word;
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign cpu_hold = !(done && !err_q);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of instruction memory (1024 words, index = PC[9:0]).
REQ-002 Parameter MAX_WORDS, default 1024, largest legal program length in words.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a load session.
REQ-006 rx_valid  input  1  byte-stream valid.
REQ-007 rx_data  input  8  byte-stream payload.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  output  ADDR_W  instruction-memory word address.
REQ-011 im_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  high keeps the processor PC frozen/in reset.
REQ-013 done  output  1  load session finished (level).
REQ-014 err  output  1  last session rejected, length illegal (level).

Function
REQ-015 A byte SHALL be consumed only on a cycle where rx_valid and rx_ready are both 1; rx_data is ignored otherwise.
REQ-016 States: IDLE, LEN_HI, LEN_LO, BYTES, WRITE, DONE.
REQ-017 IDLE: rx_ready=0, cpu_hold=1, done=0; start -> LEN_HI.
REQ-018 LEN_HI/LEN_LO: rx_ready=1; the two consumed bytes form 16-bit word count N, big-endian (first byte = N[15:8]).
REQ-019 After LEN_LO: N=0 -> DONE, err=0, no writes; N>MAX_WORDS -> DONE, err=1, no writes; otherwise -> BYTES.
REQ-020 BYTES: rx_ready=1; four consumed bytes form one word big-endian (first byte = bits 31:24); the fourth byte moves to WRITE.
REQ-021 WRITE: exactly one cycle, rx_ready=0, im_we=1, im_addr=current word index, im_wdata=assembled word.
REQ-022 Word index SHALL start at 0 each session and increment by 1 after each WRITE; it never wraps because N<=MAX_WORDS.
REQ-023 After WRITE: words written = N -> DONE, else -> BYTES.
REQ-024 DONE: rx_ready=0, im_we=0, done=1, cpu_hold=0 unless err=1 (err keeps cpu_hold=1).
REQ-025 start in DONE SHALL clear done and err and go to LEN_HI with cpu_hold=1; start in any other state SHALL be ignored.
REQ-026 rx_valid gaps of any length in LEN_HI/LEN_LO/BYTES SHALL stall without state change.
REQ-027 im_we SHALL be 0 in every state except WRITE; im_addr/im_wdata are don't-care when im_we=0.
REQ-028 Sustained throughput: one word per 5 cycles with rx_valid held high.

Reset
REQ-029 reset low SHALL immediately force IDLE, word index 0, N 0, byte counter 0, rx_ready=0, im_we=0, cpu_hold=1, done=0, err=0.
REQ-030 Reset mid-session SHALL abandon the session; memory words already written are not cleared, and a partial word is never written.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enumeration, MAX_WORDS default, and length width constant 16.
REQ-032 Sub-module byte_packer SHALL assemble four bytes into a 32-bit big-endian word and flag the fourth byte; the FSM and counters stay in imem_loader.

Verification
REQ-033 start, bytes 00 02 | 24 08 00 05 | AC 08 00 00 -> writes addr0=0x24080005, addr1=0xAC080000, done=1, cpu_hold=0, err=0.
REQ-034 start, bytes 00 00 -> DONE with no im_we pulse, done=1, err=0.
REQ-035 start, bytes 04 01 (N=1025) -> DONE, err=1, cpu_hold=1, no writes; then start plus a valid 1-word load clears err.
REQ-036 Load N=3 with rx_valid toggling randomly -> same three words/addresses as gap-free, im_we pulses exactly 3 times.
REQ-037 Assert reset after 2 of 4 payload bytes of word 1 -> all outputs at reset values at once, no write of the partial word, next session starts at addr 0.
REQ-038 Load N=1024 of incrementing words -> last write addr=0x3FF, data=0x000003FF, then done=1.
